// File: rtl/pipeline_pkg.sv
// Shared types for the elastic pipeline register chain.
package pipeline_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } pstate_t;

    function automatic logic [1:0] pstate_count(input pstate_t s);
        case (s)
            PS_ONE:  return 2'd1;
            PS_TWO:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipeline_elastic_stage.sv
// One elastic stage: main register plus optional skid register under valid/ready.
module pipeline_elastic_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SKID   = 1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    pstate_t           r_state;
    pstate_t           w_next_state;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic [DATA_W-1:0] w_next_main;
    logic [DATA_W-1:0] w_next_skid;
    logic              w_push;
    logic              w_pop;
    logic              w_ready_raw;

    // With a skid entry, ready depends only on local state; without it, ready passes through.
    assign w_ready_raw = (SKID != 0) ? (r_state != PS_TWO)
                                     : ((r_state == PS_EMPTY) | out_ready);
    assign in_ready    = w_ready_raw & ~flush;
    assign out_valid   = (r_state != PS_EMPTY);
    assign out_data    = r_main;
    assign count       = pstate_count(r_state);
    assign w_push      = in_valid & in_ready;
    assign w_pop       = out_valid & out_ready;

    always_comb begin
        w_next_state = r_state;
        w_next_main  = r_main;
        w_next_skid  = r_skid;
        case (r_state)
            PS_EMPTY: begin
                if (w_push) begin
                    w_next_state = PS_ONE;
                    w_next_main  = in_data;
                end
            end
            PS_ONE: begin
                if (w_push && w_pop) begin
                    w_next_main = in_data;
                end else if (w_pop) begin
                    w_next_state = PS_EMPTY;
                    w_next_main  = '0;
                end else if (w_push) begin
                    w_next_state = PS_TWO;
                    w_next_skid  = in_data;
                end
            end
            PS_TWO: begin
                if (w_pop) begin
                    w_next_state = PS_ONE;
                    w_next_main  = r_skid;
                    w_next_skid  = '0;
                end
            end
            default: begin
                w_next_state = PS_EMPTY;
                w_next_main  = '0;
                w_next_skid  = '0;
            end
        endcase
        if (flush) begin
            w_next_state = PS_EMPTY;
            w_next_main  = '0;
            w_next_skid  = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= PS_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_next_state;
            r_main  <= w_next_main;
            r_skid  <= w_next_skid;
        end
    end

endmodule

// File: rtl/pipeline_elastic.sv
// Elastic pipeline register: DEPTH chained valid/ready stages with flush and occupancy.
module pipeline_elastic
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1,
    parameter int unsigned SKID   = 1
) (
    input  logic                           CLK,
    input  logic                           nRST,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_W-1:0]              in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_W-1:0]              out_data,
    output logic [$clog2(2*DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned OCC_W = $clog2(2*DEPTH+1);

    logic [DEPTH:0]             w_valid;
    logic [DEPTH:0]             w_ready;
    logic [DEPTH:0][DATA_W-1:0] w_data;
    logic [DEPTH-1:0][1:0]      w_cnt;
    logic [OCC_W-1:0]           w_occ;

    assign w_valid[0]     = in_valid;
    assign w_data[0]      = in_data;
    assign in_ready       = w_ready[0];
    assign out_valid      = w_valid[DEPTH];
    assign out_data       = w_data[DEPTH];
    assign w_ready[DEPTH] = out_ready;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        pipeline_elastic_stage #(
            .DATA_W (DATA_W),
            .SKID   (SKID)
        ) u_stage (
            .CLK       (CLK),
            .nRST      (nRST),
            .flush     (flush),
            .in_valid  (w_valid[g]),
            .in_ready  (w_ready[g]),
            .in_data   (w_data[g]),
            .out_valid (w_valid[g+1]),
            .out_ready (w_ready[g+1]),
            .out_data  (w_data[g+1]),
            .count     (w_cnt[g])
        );
    end

    always_comb begin
        w_occ = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + OCC_W'(w_cnt[i]);
        end
    end

    assign occupancy = w_occ;

endmodule

// File: doc/pipeline_elastic.md
# pipeline_elastic

Parametrised elastic pipeline register: a chain of DEPTH stages carrying an opaque DATA_W-bit bundle (decoded control plus operands) between CPU pipeline stages. Valid/ready handshaking replaces the single global enable, so a stall propagates backward one stage per cycle without losing data. Synchronous flush squashes every in-flight bundle to the all-zero bubble, and zero control means no register write and no memory access. Used for the IF/ID, ID/EX and EX/MEM boundaries and for multi-cycle FU front-ends.

## Interface
- DATA_W, 32: bundle width in bits, 1 or more.
- DEPTH, 1: number of chained stages, 1 or more.
- SKID, 1: 1 = two-entry stage (main plus skid), full throughput with registered in_ready; 0 = single-entry stage, in_ready combinational from out_ready.
- CLK  in  1  rising-edge clock.
- nRST  in  1  reset, synchronous and active-low.
- flush  in  1  synchronous squash of all stages.
- in_valid  in  1  upstream bundle valid.
- in_ready  out  1  chain accepts the bundle this cycle.
- in_data  in  DATA_W  upstream bundle.
- out_valid  out  1  head bundle valid.
- out_ready  in  1  downstream accepts the head.
- out_data  out  DATA_W  head bundle; all-zero whenever out_valid=0.
- occupancy  out  $clog2(2*DEPTH+1)  bundles currently held.

## Operation
- Handshake: a transfer occurs on a cycle where valid and ready are both 1, sampled at the rising edge of CLK. in_valid must not depend on in_ready. Once asserted, out_valid and out_data hold until the transfer.
- Per-stage state (SKID=1):
  - EMPTY: no data held; ready=1.
  - ONE: main register valid; ready=1.
  - TWO: main and skid registers valid; ready=0.
- Transitions (push = in transfer, pop = out transfer):
  - EMPTY goes to ONE on push.
  - ONE stays ONE on push with pop; goes to EMPTY on pop only; goes to TWO on push only.
  - TWO goes to ONE on pop. The skid word moves to main.
- SKID=0: the stage has two states, EMPTY and ONE. ready = ~valid | downstream ready.
- Ordering is strictly FIFO. No bundle is dropped or duplicated except by flush.
- Flush:
  - At the next edge, every stage goes to EMPTY and every data register goes to 0.
  - in_ready is forced to 0 during the flush cycle, so no push happens.
  - A pop in the flush cycle still counts as a transfer: downstream takes the current head.
- Precedence: reset over flush over push/pop.
- Reset (nRST=0 at an edge): all stages EMPTY, all data 0. After the edge, out_valid=0, out_data=0, occupancy=0. in_ready=1, except when flush=1 (forced 0).
- occupancy is the sum of valid entries across all stages. It is 2*DEPTH maximum with SKID=1 and DEPTH with SKID=0.

## Timing
- Latency from push to out_valid is DEPTH cycles, with the chain empty and out_ready=1.
- Throughput is 1 bundle/cycle in steady state for both SKID values.
- SKID=1:
  - in_ready is a pure function of stage-0 state and flush, with no combinational path from out_ready.
  - out_ready deasserting is seen at in_ready after DEPTH cycles at the latest.
- SKID=0: there is a combinational out_ready-to-in_ready path through all DEPTH stages.
- All outputs come from registers except in_ready (gated by flush) and, when SKID=0, in_ready.

## Structure
- pipeline_pkg: typedef enum logic [1:0] pstate_t {PS_EMPTY, PS_ONE, PS_TWO}. Bubble constant is all-zero; no bundle typedef, since bundles stay opaque logic vectors.
- Sub-module pipeline_elastic_stage, with parameters DATA_W and SKID, holds one stage: state machine plus main and skid registers.
- The top level generate-chains DEPTH instances, broadcasts flush and reset, and sums per-stage counts into occupancy.

## Test plan
- Reset: nRST=0 for 2 cycles with in_valid=1 and in_data=0xDEAD_BEEF, then release. Required: out_valid=0, out_data=0, occupancy=0, in_ready=1, and nothing emitted.
- Streaming: DEPTH=3, SKID=1, push 0x1..0x10 on consecutive cycles with out_ready=1. Required: 0x1 appears 3 cycles after its push, then one word/cycle in order, occupancy steady at 3.
- Backpressure: DEPTH=1, SKID=1, out_ready=0 while pushing 0xA, 0xB, 0xC. Required: 0xA and 0xB accepted, in_ready=0 on the cycle 0xC is offered, occupancy=2. After out_ready=1, the order is 0xA, 0xB, then 0xC, with no loss.
- Flush with a simultaneous pop: DEPTH=2 holding 0x5 (head) and 0x6, with flush=1, out_ready=1, in_valid=1 carrying 0x7. Required: 0x5 is transferred that cycle; the next cycle shows out_valid=0, out_data=0, occupancy=0; 0x7 is never emitted.
- SKID=0, DEPTH=2, random valid/ready stimulus for 10k cycles. Required: the scoreboard matches in FIFO order, occupancy never exceeds 2, and in_ready equals ~valid0 | ready1 every cycle.
- Reset mid-stream: nRST=0 while the chain holds 4 bundles and out_ready=0. Required: everything is empty at the next edge, and the first push afterwards appears with nominal latency.
